// File: rtl/sram_model_pkg.sv
// Shared types and helpers for the write-tracking SRAM model.
package sram_model_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN} sweep_state_t;

  localparam int UB_LANE = 1;
  localparam int LB_LANE = 0;

  function automatic logic in_window(input int unsigned addr, input int unsigned lo,
                                     input int unsigned hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/sram_model_tracked_if.sv
// SRAM control bus plus sweep control/status of the write-tracking model.
interface sram_model_tracked_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned CNT_W  = 20
);
  logic [ADDR_W-1:0] SRAM_address;
  logic              SRAM_UB_N, SRAM_LB_N;
  logic              SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;
  logic              Clear_i, Scan_i;
  logic              Busy_o, Scan_done_o;
  logic [CNT_W-1:0]  Write_count_o, Region_viol_o, Multi_write_o, Unwritten_o;

  modport master (
    output SRAM_address, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
           Clear_i, Scan_i,
    input  Busy_o, Scan_done_o, Write_count_o, Region_viol_o, Multi_write_o, Unwritten_o
  );

  modport slave (
    input  SRAM_address, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N,
           Clear_i, Scan_i,
    output Busy_o, Scan_done_o, Write_count_o, Region_viol_o, Multi_write_o, Unwritten_o
  );
endinterface

// File: rtl/sram_read_pipe.sv
// Valid/address delay line for reads; flushed by the asynchronous reset.
module sram_read_pipe #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned STAGES = 1
) (
  input  logic              Clock_50,
  input  logic              Resetn,
  input  logic              in_vld,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_vld,
  output logic [ADDR_W-1:0] out_addr
);
  logic [STAGES:1]             vld_pipe;
  logic [STAGES:1][ADDR_W-1:0] addr_pipe;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[1]  <= in_vld;
      addr_pipe[1] <= in_addr;
      for (int s = 2; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        addr_pipe[s] <= addr_pipe[s-1];
      end
    end
  end

  assign out_vld  = vld_pipe[STAGES];
  assign out_addr = addr_pipe[STAGES];
endmodule

// File: rtl/sram_model_tracked.sv
// Write-tracking async-SRAM model with clear/scan sweep engine.
// SRAM_MODEL_WRITE_TRACK_EN builds the tracking bitmap, multi-write counter and SCAN.
module sram_model_tracked
  import sram_model_pkg::*;
#(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned WR_LO        = 0,
  parameter int unsigned WR_HI        = 76799,
  parameter int unsigned CHK_LO       = 0,
  parameter int unsigned CHK_HI       = 76799,
  parameter int unsigned CNT_W        = 20
) (
  input  logic                Clock_50,
  input  logic                Resetn,
  inout  wire  [DATA_W-1:0]   SRAM_data_io,
  sram_model_tracked_if.slave bus
);
  localparam int unsigned       HALF     = DATA_W / 2;
  localparam logic [ADDR_W-1:0] CHK_LO_A = ADDR_W'(CHK_LO);
  localparam logic [ADDR_W-1:0] CHK_HI_A = ADDR_W'(CHK_HI);

  sweep_state_t      state, state_nxt;
  logic [ADDR_W-1:0] sweep_addr;
  logic              busy, clr_last, scan_last;
  logic              wr_acc, rd_acc;
  logic [1:0]        lane_we;
  logic              rd_vld_q, drive_en;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              ev_wr, ev_oob;
  logic [CNT_W-1:0]  wr_cnt, oob_cnt;

  assign busy      = (state != IDLE);
  assign clr_last  = &sweep_addr;
  assign scan_last = (sweep_addr == CHK_HI_A);
  assign wr_acc    = !busy && !bus.SRAM_CE_N && !bus.SRAM_WE_N;
  assign rd_acc    = !busy && !bus.SRAM_CE_N && bus.SRAM_WE_N && !bus.SRAM_OE_N;
  assign lane_we[UB_LANE] = wr_acc && !bus.SRAM_UB_N;
  assign lane_we[LB_LANE] = wr_acc && !bus.SRAM_LB_N;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.Clear_i) state_nxt = CLEAR;
`ifdef SRAM_MODEL_WRITE_TRACK_EN
        else if (bus.Scan_i) state_nxt = SCAN;
`endif
      end
      CLEAR:   if (clr_last)  state_nxt = IDLE;
      SCAN:    if (scan_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      sweep_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) sweep_addr <= bus.Clear_i ? '0 : CHK_LO_A;
      else               sweep_addr <= sweep_addr + 1'b1;
    end
  end

  // Array has no reset: contents survive Resetn, only CLEAR erases them.
  always_ff @(posedge Clock_50) begin
    if (state == CLEAR) mem[sweep_addr] <= '0;
    else
      for (int l = 0; l < 2; l++)
        if (lane_we[l]) mem[bus.SRAM_address][l*HALF +: HALF] <= SRAM_data_io[l*HALF +: HALF];
  end

  sram_read_pipe #(.ADDR_W(ADDR_W), .STAGES(READ_LATENCY)) u_rd_pipe (
    .Clock_50 (Clock_50),
    .Resetn   (Resetn),
    .in_vld   (rd_acc),
    .in_addr  (bus.SRAM_address),
    .out_vld  (rd_vld_q),
    .out_addr (rd_addr_q)
  );

  // A write on the bus in the exit cycle owns the bus.
  assign drive_en     = rd_vld_q && !busy && !wr_acc;
  assign SRAM_data_io = drive_en ? mem[rd_addr_q] : {DATA_W{1'bz}};

  // Counters lag the sampling edge by one edge through the ev_* flops.
  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      ev_wr   <= 1'b0;
      ev_oob  <= 1'b0;
      wr_cnt  <= '0;
      oob_cnt <= '0;
    end else begin
      ev_wr  <= wr_acc;
      ev_oob <= wr_acc && !in_window(32'(bus.SRAM_address), WR_LO, WR_HI);
      if (state == CLEAR) begin
        wr_cnt  <= '0;
        oob_cnt <= '0;
      end else begin
        if (ev_wr  && !(&wr_cnt))  wr_cnt  <= wr_cnt + 1'b1;
        if (ev_oob && !(&oob_cnt)) oob_cnt <= oob_cnt + 1'b1;
      end
    end
  end

  assign bus.Busy_o        = busy;
  assign bus.Write_count_o = wr_cnt;
  assign bus.Region_viol_o = oob_cnt;

`ifdef SRAM_MODEL_WRITE_TRACK_EN
  logic             wr_map [2**ADDR_W];
  logic             ev_dup, miss, scan_done;
  logic [CNT_W-1:0] mw_cnt, scan_cnt, unwr;

  always_ff @(posedge Clock_50) begin
    if (state == CLEAR) wr_map[sweep_addr] <= 1'b0;
    else if (wr_acc)    wr_map[bus.SRAM_address] <= 1'b1;
  end

  assign miss = !wr_map[sweep_addr];

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      ev_dup    <= 1'b0;
      mw_cnt    <= '0;
      scan_cnt  <= '0;
      unwr      <= '0;
      scan_done <= 1'b0;
    end else begin
      ev_dup    <= wr_acc && wr_map[bus.SRAM_address];
      scan_done <= 1'b0;
      if (state == CLEAR)              mw_cnt <= '0;
      else if (ev_dup && !(&mw_cnt))   mw_cnt <= mw_cnt + 1'b1;
      if (state == IDLE) scan_cnt <= '0;
      else if (state == SCAN) begin
        if (miss && !(&scan_cnt)) scan_cnt <= scan_cnt + 1'b1;
        if (scan_last) begin
          unwr      <= (miss && !(&scan_cnt)) ? scan_cnt + 1'b1 : scan_cnt;
          scan_done <= 1'b1;
        end
      end
    end
  end

  assign bus.Multi_write_o = mw_cnt;
  assign bus.Unwritten_o   = unwr;
  assign bus.Scan_done_o   = scan_done;
`else
  assign bus.Multi_write_o = '0;
  assign bus.Unwritten_o   = '0;
  assign bus.Scan_done_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_model_tracked.sv
// Directed bench for sram_model_tracked; undriven bus bits are pulled up, so high-Z reads as FFFF.
module tb_sram_model_tracked;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 20;
`ifdef SRAM_MODEL_WRITE_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  logic          clock_50 = 1'b0;
  logic          resetn   = 1'b0;
  logic          tb_en    = 1'b0;
  logic [DW-1:0] tb_dat   = '0;
  wire  [DW-1:0] data_bus;
  int            n_chk    = 0;
  int            n_fail   = 0;
  logic [DW-1:0] pre, rdat;

  assign data_bus = tb_en ? tb_dat : {DW{1'bz}};
  for (genvar b = 0; b < DW; b++) begin : g_pu
    pullup (data_bus[b]);
  end

  sram_model_tracked_if #(.ADDR_W(AW), .CNT_W(CW)) sif ();

  sram_model_tracked #(
    .ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .WR_LO(0), .WR_HI(76799),
    .CHK_LO(0), .CHK_HI(15), .CNT_W(CW)
  ) dut (
    .Clock_50     (clock_50),
    .Resetn       (resetn),
    .SRAM_data_io (data_bus),
    .bus          (sif.slave)
  );

  always #5 clock_50 = ~clock_50;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_50);
    #1;
  endtask

  task automatic idle();
    sif.SRAM_CE_N = 1'b1; sif.SRAM_WE_N = 1'b1; sif.SRAM_OE_N = 1'b1;
    sif.SRAM_UB_N = 1'b0; sif.SRAM_LB_N = 1'b0;
    tb_en = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic ub_n, input logic lb_n);
    sif.SRAM_address = a; sif.SRAM_CE_N = 1'b0; sif.SRAM_WE_N = 1'b0;
    sif.SRAM_UB_N = ub_n; sif.SRAM_LB_N = lb_n;
    tb_dat = d; tb_en = 1'b1;
    step();
    idle();
  endtask

  // Latency 2: high-Z in the first cycle after sampling, data in the second.
  task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] p, output logic [DW-1:0] d);
    sif.SRAM_address = a; sif.SRAM_CE_N = 1'b0; sif.SRAM_WE_N = 1'b1; sif.SRAM_OE_N = 1'b0;
    step();
    idle();
    @(negedge clock_50); p = data_bus;
    @(negedge clock_50); d = data_bus;
    step();
  endtask

  initial begin
    int n_busy, n_done, n_sd;
    logic fell, done_at_fall;
    idle();
    sif.SRAM_address = '0; sif.Clear_i = 1'b0; sif.Scan_i = 1'b0;

    #3;
    chk("rst_busy", sif.Busy_o, 0);
    chk("rst_wcnt", sif.Write_count_o, 0);
    chk("rst_region", sif.Region_viol_o, 0);
    chk("rst_unwritten", sif.Unwritten_o, 0);
    chk("rst_bus_hiz", data_bus, 16'hFFFF);
    #19 resetn = 1'b1;
    step();

    wr(17'd5, 16'hA55A, 1'b0, 1'b0);
    rd(17'd5, pre, rdat);
    chk("basic_pre_hiz", pre, 16'hFFFF);
    chk("basic_data", rdat, 16'hA55A);
    chk("basic_wcnt", sif.Write_count_o, 1);

    wr(17'd9, 16'h1234, 1'b0, 1'b0);
    rd(17'd9, pre, rdat);
    chk("raw_data", rdat, 16'h1234);
    wr(17'd9, 16'hFFFF, 1'b1, 1'b0);
    rd(17'd9, pre, rdat);
    chk("lane_lb_only", rdat, 16'h12FF);

    // read of 5 exits while a lane-less write to 7 is on the bus
    sif.SRAM_address = 17'd5; sif.SRAM_CE_N = 1'b0; sif.SRAM_WE_N = 1'b1; sif.SRAM_OE_N = 1'b0;
    step();
    idle();
    step();
    sif.SRAM_address = 17'd7; sif.SRAM_CE_N = 1'b0; sif.SRAM_WE_N = 1'b0;
    sif.SRAM_UB_N = 1'b1; sif.SRAM_LB_N = 1'b1;
    @(negedge clock_50);
    chk("wr_over_rd_hiz", data_bus, 16'hFFFF);
    step();
    idle();
    step();
    chk("nolane_wcnt", sif.Write_count_o, 4);
    chk("nolane_region", sif.Region_viol_o, 0);
    chk("multi_9", sif.Multi_write_o, TRK ? 1 : 0);

    // async reset between edges clears counters but keeps the array
    resetn = 1'b0;
    #1;
    chk("rst2_wcnt", sif.Write_count_o, 0);
    chk("rst2_multi", sif.Multi_write_o, 0);
    #3 resetn = 1'b1;
    step();

    wr(17'd76800, 16'h0BAD, 1'b0, 1'b0);
    wr(17'd3, 16'h3333, 1'b0, 1'b0);
    wr(17'd3, 16'h3344, 1'b0, 1'b0);
    step(); step();
    chk("region_viol", sif.Region_viol_o, 1);
    chk("region_wcnt", sif.Write_count_o, 3);
    chk("region_multi", sif.Multi_write_o, TRK ? 1 : 0);
    rd(17'd76800, pre, rdat);
    chk("region_wr_done", rdat, 16'h0BAD);
    rd(17'd9, pre, rdat);
    chk("reset_keeps_9", rdat, 16'h12FF);

    for (int i = 0; i < 10; i++) wr(AW'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
    step();

    sif.Scan_i = 1'b1;
    step();
    sif.Scan_i = 1'b0;
`ifdef SRAM_MODEL_WRITE_TRACK_EN
    sif.SRAM_address = 17'd12; sif.SRAM_CE_N = 1'b0; sif.SRAM_WE_N = 1'b0;
    tb_dat = 16'h5A5A; tb_en = 1'b1;
    n_busy = 0; n_done = 0; fell = 1'b0; done_at_fall = 1'b0;
    for (int i = 0; i < 64 && !fell; i++) begin
      @(negedge clock_50);
      if (i == 1) idle();
      if (sif.Busy_o) n_busy++;
      else begin
        fell = 1'b1;
        done_at_fall = sif.Scan_done_o;
      end
      if (sif.Scan_done_o) n_done++;
    end
    chk("scan_ended", fell, 1);
    chk("scan_busy_cycles", n_busy, 16);
    chk("scan_done_at_fall", done_at_fall, 1);
    chk("scan_done_pulses", n_done, 1);
    @(negedge clock_50);
    chk("scan_done_one_cycle", sif.Scan_done_o, 0);
    chk("scan_unwritten", sif.Unwritten_o, 6);
`else
    n_sd = 0;
    @(negedge clock_50);
    chk("scan_ignored_busy", sif.Busy_o, 0);
    repeat (20) begin
      @(negedge clock_50);
      if (sif.Scan_done_o) n_sd++;
    end
    chk("scan_ignored_done", n_sd, 0);
    chk("scan_ignored_unwr", sif.Unwritten_o, 0);
`endif
    step();
    chk("busy_wr_dropped_wcnt", sif.Write_count_o, 13);

    wr(17'd100, 16'h7777, 1'b0, 1'b0);
    wr(17'd200, 16'h0C0C, 1'b0, 1'b0);
    sif.Clear_i = 1'b1;
    step();
    sif.Clear_i = 1'b0;
    sif.SRAM_address = 17'd200; sif.SRAM_CE_N = 1'b0; sif.SRAM_WE_N = 1'b0;
    tb_dat = 16'h1111; tb_en = 1'b1;
    step();
    idle();
    repeat (99) step();
    chk("clear_busy", sif.Busy_o, 1);
    chk("clear_wcnt_zero", sif.Write_count_o, 0);
    resetn = 1'b0;
    #1;
    chk("midclr_busy", sif.Busy_o, 0);
    chk("midclr_wcnt", sif.Write_count_o, 0);
    chk("midclr_region", sif.Region_viol_o, 0);
    chk("midclr_bus_hiz", data_bus, 16'hFFFF);
    #10 resetn = 1'b1;
    step();
    chk("post_rst_busy", sif.Busy_o, 0);
    rd(17'd3, pre, rdat);
    chk("cleared_3", rdat, 16'h0000);
    rd(17'd5, pre, rdat);
    chk("cleared_5", rdat, 16'h0000);
    rd(17'd100, pre, rdat);
    chk("kept_100", rdat, 16'h7777);
    rd(17'd200, pre, rdat);
    chk("kept_200_busy_wr_dropped", rdat, 16'h0C0C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
